gf180mcu_ef_io__bi_t_ctrl: RTL and testbench

Sequencing and configuration controller for one bidirectional 5V GPIO pad cell. It owns every pad control pin (CS, SL, IE, OE, PU, PD, A, PDRV0, PDRV1) and enforces a safe power-on state. Every configuration write passes through a timed hi-Z turnaround, so the pad and the external bus never drive against each other. It also synchronises and debounces the pad's Y return into a clean core-side input with edge pulses.

---
 rtl/gf180mcu_ef_io__bi_t_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_gf180mcu_ef_io__bi_t_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_ef_io__bi_t_ctrl.sv
// Sequencing and configuration controller for one bidirectional 5V GPIO pad.
//
// Every accepted configuration write forces the pad into hi-Z (OE=0, IE=0) for
// TURN_CYCLES cycles before the new MODE takes effect. This stops the pad and
// the external bus from driving against each other. The pad's Y return is
// synchronised and debounced into DIN, which comes with one-cycle edge pulses.
//
// Ports
//   clk_i              core clock, rising edge
//   rst_ni             asynchronous active-low reset
//   cfg_we_i           config write strobe (single cycle)
//   cfg_wdata_i[7:0]   {SCHMITT, SLEW, DRIVE[1:0], PULL[1:0], MODE[1:0]}
//   cfg_rdata_o[7:0]   currently committed config
//   cfg_err_o          one-cycle pulse when a write arrives during turnaround
//   busy_o             high during turnaround
//   dout_i             core data to pad
//   din_o              debounced pad input
//   din_rise_o/fall_o  one-cycle pulses on DIN 0->1 / 1->0
//   y_i                pad cell Y
//   cs_o .. pdrv1_o    pad cell control pins of the same name
module gf180mcu_ef_io__bi_t_ctrl #(
   parameter int unsigned TURN_CYCLES = 4,
   parameter int unsigned DEB_CYCLES  = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cfg_we_i,
   input  logic [7:0] cfg_wdata_i,
   output logic [7:0] cfg_rdata_o,
   output logic       cfg_err_o,
   output logic       busy_o,
   input  logic       dout_i,
   output logic       din_o,
   output logic       din_rise_o,
   output logic       din_fall_o,
   input  logic       y_i,
   output logic       cs_o,
   output logic       sl_o,
   output logic       ie_o,
   output logic       oe_o,
   output logic       pu_o,
   output logic       pd_o,
   output logic       a_o,
   output logic       pdrv0_o,
   output logic       pdrv1_o
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StTurn   = 2'd1;
   localparam logic [1:0] StActive = 2'd2;

   localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES - 1);
   localparam logic [8:0] DebLimit = 9'(DEB_CYCLES);

   logic [1:0] state_q, state_d;
   logic [3:0] turn_cnt_q, turn_cnt_d;
   logic [7:0] cfg_q, cfg_d;
   logic       cfg_err_q, cfg_err_d;
   // {cs, sl, pdrv1, pdrv0, pd, pu}, registered alongside the committed config
   logic [5:0] pad_q, pad_d;

   logic       sync1_q, sync2_q;
   logic [7:0] deb_cnt_q, deb_cnt_d;
   logic       din_q, din_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;

   // ---------------------------------------------------------------------------
   // Configuration / turnaround sequencing
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      turn_cnt_d = turn_cnt_q;
      cfg_d      = cfg_q;
      cfg_err_d  = 1'b0;
      if (cfg_we_i && (state_q != StTurn)) begin
         cfg_d      = cfg_wdata_i;
         turn_cnt_d = TurnLoad;
         state_d    = StTurn;
      end else if (state_q == StTurn) begin
         // A write during turnaround is dropped; the countdown is not restarted.
         cfg_err_d = cfg_we_i;
         if (turn_cnt_q == 4'd0) begin
            state_d = StActive;
         end else begin
            turn_cnt_d = turn_cnt_q - 4'd1;
         end
      end
   end

   always_comb begin
      pad_d[0] = (cfg_d[3:2] == 2'b01);
      pad_d[1] = (cfg_d[3:2] == 2'b10);
      pad_d[2] = cfg_d[4];
      pad_d[3] = cfg_d[5];
      pad_d[4] = cfg_d[6];
      pad_d[5] = cfg_d[7];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         turn_cnt_q <= 4'd0;
         cfg_q      <= 8'd0;
         cfg_err_q  <= 1'b0;
         pad_q      <= 6'd0;
      end else begin
         state_q    <= state_d;
         turn_cnt_q <= turn_cnt_d;
         cfg_q      <= cfg_d;
         cfg_err_q  <= cfg_err_d;
         pad_q      <= pad_d;
      end
   end

   // OE/IE/A are decoded combinationally so DOUT reaches the pad with no added latency.
   always_comb begin
      oe_o = 1'b0;
      ie_o = 1'b0;
      a_o  = 1'b0;
      if (state_q == StActive) begin
         unique case (cfg_q[1:0])
            2'b00: ;
            2'b01: ie_o = 1'b1;
            2'b10: begin
               oe_o = 1'b1;
               ie_o = 1'b1;
               a_o  = dout_i;
            end
            2'b11: begin
               oe_o = ~dout_i;
               ie_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Input path: 2-flop synchroniser + counter debounce
   // ---------------------------------------------------------------------------
   always_comb begin
      deb_cnt_d = 8'd0;
      din_d     = din_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (ie_o && (sync2_q != din_q)) begin
         if (({1'b0, deb_cnt_q} + 9'd1) == DebLimit) begin
            din_d  = sync2_q;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_cnt_q <= 8'd0;
         din_q     <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         sync1_q   <= y_i;
         sync2_q   <= sync1_q;
         deb_cnt_q <= deb_cnt_d;
         din_q     <= din_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign cfg_rdata_o = cfg_q;
   assign cfg_err_o   = cfg_err_q;
   assign busy_o      = (state_q == StTurn);
   assign pu_o        = pad_q[0];
   assign pd_o        = pad_q[1];
   assign pdrv0_o     = pad_q[2];
   assign pdrv1_o     = pad_q[3];
   assign sl_o        = pad_q[4];
   assign cs_o        = pad_q[5];
   assign din_o       = din_q;
   assign din_rise_o  = rise_q;
   assign din_fall_o  = fall_q;

endmodule

// File: tb/tb_gf180mcu_ef_io__bi_t_ctrl.sv
// Self-checking bench for gf180mcu_ef_io__bi_t_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model of the pad controller.
module tb_gf180mcu_ef_io__bi_t_ctrl;

   localparam int TURN = 4;
   localparam int DEB  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_ni, cfg_we_i, dout_i, y_i;
   logic [7:0] cfg_wdata_i, cfg_rdata_o;
   logic       cfg_err_o, busy_o, din_o, din_rise_o, din_fall_o;
   logic       cs_o, sl_o, ie_o, oe_o, pu_o, pd_o, a_o, pdrv0_o, pdrv1_o;

   int vectors    = 0;
   int miscompares = 0;

   gf180mcu_ef_io__bi_t_ctrl #(
      .TURN_CYCLES(TURN),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .cfg_we_i   (cfg_we_i),
      .cfg_wdata_i(cfg_wdata_i),
      .cfg_rdata_o(cfg_rdata_o),
      .cfg_err_o  (cfg_err_o),
      .busy_o     (busy_o),
      .dout_i     (dout_i),
      .din_o      (din_o),
      .din_rise_o (din_rise_o),
      .din_fall_o (din_fall_o),
      .y_i        (y_i),
      .cs_o       (cs_o),
      .sl_o       (sl_o),
      .ie_o       (ie_o),
      .oe_o       (oe_o),
      .pu_o       (pu_o),
      .pd_o       (pd_o),
      .a_o        (a_o),
      .pdrv0_o    (pdrv0_o),
      .pdrv1_o    (pdrv1_o)
   );

   logic [21:0] dut_vec;
   assign dut_vec = {cfg_rdata_o, cfg_err_o, busy_o, din_o, din_rise_o, din_fall_o, cs_o, sl_o,
                     ie_o, oe_o, pu_o, pd_o, a_o, pdrv0_o, pdrv1_o};

   // ---------------------------------------------------------------------------
   // Behavioural model: remaining busy cycles, committed config, and a run
   // length of consecutive "synchronised Y disagrees with DIN while IE" cycles.
   // ---------------------------------------------------------------------------
   logic [7:0] m_cfg;
   int         m_left, m_run;
   logic       m_active, m_err, m_s1, m_s2, m_din, m_rise, m_fall;

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_cfg <= 8'd0; m_left <= 0; m_run <= 0; m_active <= 1'b0; m_err <= 1'b0;
         m_s1 <= 1'b0; m_s2 <= 1'b0; m_din <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
      end else begin
         if (m_active && (m_cfg[1:0] != 2'b00) && (m_s2 != m_din)) begin
            if (m_run + 1 == DEB) begin
               m_din <= m_s2; m_rise <= m_s2; m_fall <= ~m_s2; m_run <= 0;
            end else begin
               m_run <= m_run + 1; m_rise <= 1'b0; m_fall <= 1'b0;
            end
         end else begin
            m_run <= 0; m_rise <= 1'b0; m_fall <= 1'b0;
         end
         m_s1  <= y_i;
         m_s2  <= m_s1;
         m_err <= cfg_we_i && (m_left > 0);
         if (cfg_we_i && (m_left == 0)) begin
            m_cfg <= cfg_wdata_i; m_left <= TURN; m_active <= 1'b0;
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_active <= 1'b1;
         end
      end
   end

   function automatic logic [21:0] model_vec();
      logic oe, ie, a;
      oe = 1'b0; ie = 1'b0; a = 1'b0;
      if (m_active) begin
         case (m_cfg[1:0])
            2'b01: ie = 1'b1;
            2'b10: begin oe = 1'b1; ie = 1'b1; a = dout_i; end
            2'b11: begin oe = ~dout_i; ie = 1'b1; end
            default: ;
         endcase
      end
      return {m_cfg, m_err, (m_left > 0), m_din, m_rise, m_fall, m_cfg[7], m_cfg[6], ie, oe,
              (m_cfg[3:2] == 2'b01), (m_cfg[3:2] == 2'b10), a, m_cfg[4], m_cfg[5]};
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic write_cfg(input logic [7:0] d);
      cfg_we_i = 1'b1; cfg_wdata_i = d;
      @(negedge clk);
      cfg_we_i = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (dut_vec !== 22'd0) begin
         miscompares++; $display("FAIL reset_state: got %h want %h", dut_vec, 22'd0);
      end
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      vectors++;
      if (dut_vec !== 22'd0) begin
         miscompares++; $display("FAIL idle_after_release: got %h want %h", dut_vec, 22'd0);
      end
      write_cfg(8'hA6);
      @(negedge clk);
      vectors++;
      if (busy_o !== 1'b1 || cfg_rdata_o !== 8'hA6) begin
         miscompares++;
         $display("FAIL busy_before_reset: got busy=%b cfg=%h want busy=1 cfg=a6", busy_o, cfg_rdata_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      vectors++;
      if (dut_vec !== 22'd0) begin
         miscompares++; $display("FAIL async_reset_mid_turn: got %h want %h", dut_vec, 22'd0);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (TURN + 3) @(negedge clk);
      vectors++;
      if (dut_vec !== 22'd0) begin
         miscompares++; $display("FAIL no_turn_completion: got %h want %h", dut_vec, 22'd0);
      end
   endtask

   // 0x16 = push-pull, PULL=01 (pull-up), DRIVE=01
   task automatic test_push_pull();
      logic [6:0] got;
      dout_i = 1'b0;
      write_cfg(8'h16);
      for (int k = 1; k <= TURN; k++) begin
         if (k > 1) @(negedge clk);
         got = {busy_o, oe_o, ie_o, pu_o, pd_o, pdrv0_o, pdrv1_o};
         vectors++;
         if (got !== 7'b1001010) begin
            miscompares++; $display("FAIL pp_turn_%0d: got %b want 1001010", k, got);
         end
      end
      @(negedge clk);
      got = {busy_o, oe_o, ie_o, pu_o, pd_o, pdrv0_o, pdrv1_o};
      vectors++;
      if (got !== 7'b0111010) begin
         miscompares++; $display("FAIL pp_active: got %b want 0111010", got);
      end
      for (int i = 0; i < 3; i++) begin
         dout_i = 1'($urandom);
         #1;
         vectors++;
         if (a_o !== dout_i || oe_o !== 1'b1) begin
            miscompares++; $display("FAIL pp_a_tracks: got a=%b oe=%b want a=%b oe=1", a_o, oe_o, dout_i);
         end
      end
   endtask

   task automatic test_open_drain();
      write_cfg(8'h03);
      repeat (TURN) @(negedge clk);
      dout_i = 1'b1;
      #1;
      vectors++;
      if ({oe_o, a_o, ie_o} !== 3'b001) begin
         miscompares++; $display("FAIL od_dout1: got oe,a,ie=%b want 001", {oe_o, a_o, ie_o});
      end
      dout_i = 1'b0;
      #1;
      vectors++;
      if ({oe_o, a_o, ie_o} !== 3'b101) begin
         miscompares++; $display("FAIL od_dout0: got oe,a,ie=%b want 101", {oe_o, a_o, ie_o});
      end
      @(negedge clk);
      write_cfg(8'h0F);
      repeat (TURN) @(negedge clk);
      vectors++;
      if ({pu_o, pd_o, oe_o, a_o} !== 4'b0010) begin
         miscompares++;
         $display("FAIL od_pull11: got pu,pd,oe,a=%b want 0010", {pu_o, pd_o, oe_o, a_o});
      end
   endtask

   task automatic test_back_to_back();
      write_cfg(8'h01);
      @(negedge clk);
      cfg_we_i = 1'b1; cfg_wdata_i = 8'h55;
      @(negedge clk);
      cfg_we_i = 1'b0;
      vectors++;
      if ({cfg_err_o, busy_o, cfg_rdata_o} !== {2'b11, 8'h01}) begin
         miscompares++;
         $display("FAIL reject_pulse: got err=%b busy=%b cfg=%h want err=1 busy=1 cfg=01",
                  cfg_err_o, busy_o, cfg_rdata_o);
      end
      @(negedge clk);
      vectors++;
      if ({cfg_err_o, busy_o} !== 2'b01) begin
         miscompares++; $display("FAIL reject_one_cycle: got err,busy=%b want 01", {cfg_err_o, busy_o});
      end
      @(negedge clk);
      vectors++;
      if ({busy_o, ie_o, cfg_rdata_o} !== {2'b01, 8'h01}) begin
         miscompares++;
         $display("FAIL busy_original_end: got busy=%b ie=%b cfg=%h want 0 1 01",
                  busy_o, ie_o, cfg_rdata_o);
      end
   endtask

   task automatic test_debounce();
      int   lat;
      logic bad;
      bad = 1'b0;
      y_i = 1'b1;
      repeat (5) @(negedge clk);
      y_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (din_o !== 1'b0 || din_rise_o !== 1'b0 || din_fall_o !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++; $display("FAIL glitch_rejected: got disturbance=1 want 0");
      end
      y_i = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (din_o === 1'b1) begin
            lat = i;
            break;
         end
      end
      vectors++;
      if (lat != DEB + 2 || din_rise_o !== 1'b1 || din_fall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL din_rise_latency: got lat=%0d rise=%b fall=%b want lat=%0d rise=1 fall=0",
                  lat, din_rise_o, din_fall_o, DEB + 2);
      end
      @(negedge clk);
      vectors++;
      if ({din_o, din_rise_o} !== 2'b10) begin
         miscompares++; $display("FAIL rise_one_cycle: got din,rise=%b want 10", {din_o, din_rise_o});
      end
      // Random-length low glitches shorter than the debounce window.
      for (int n = 0; n < 3; n++) begin
         bad = 1'b0;
         y_i = 1'b0;
         repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
         y_i = 1'b1;
         for (int i = 0; i < DEB + 4; i++) begin
            @(negedge clk);
            if (din_o !== 1'b1 || din_fall_o !== 1'b0) bad = 1'b1;
         end
         vectors++;
         if (bad) begin
            miscompares++; $display("FAIL low_glitch_%0d: got disturbance=1 want 0", n);
         end
      end
   endtask

   task automatic test_ie_hold();
      logic bad;
      bad = 1'b0;
      y_i = 1'b0;
      write_cfg(8'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (din_o !== 1'b1 || din_fall_o !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad || ie_o !== 1'b0 || oe_o !== 1'b0) begin
         miscompares++;
         $display("FAIL ie_hold: got din=%b fall_seen=%b ie=%b oe=%b want din=1 no fall ie=0 oe=0",
                  din_o, bad, ie_o, oe_o);
      end
   endtask

   task automatic test_random();
      logic [21:0] exp;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         exp = model_vec();
         vectors++;
         if (dut_vec !== exp) begin
            miscompares++; $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp);
         end
         cfg_we_i    = ($urandom_range(0, 5) == 0);
         cfg_wdata_i = 8'($urandom);
         dout_i      = 1'($urandom);
         if ($urandom_range(0, 13) == 0) y_i = ~y_i;
      end
      cfg_we_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_wdata_i = 8'd0; dout_i = 1'b0; y_i = 1'b0;
      test_reset();
      test_push_pull();
      test_open_drain();
      test_back_to_back();
      test_debounce();
      test_ie_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
